// File: rtl/dfe_pkg.sv
// Shared DFE chain definitions: saturation-flag bit positions and the sample type.
package dfe_pkg;

  localparam int NUM_SAT_FLAGS = 10;

  localparam int SAT_IIR24_OF = 0;
  localparam int SAT_IIR24_UF = 1;
  localparam int SAT_IIR2_OF  = 2;
  localparam int SAT_IIR2_UF  = 3;
  localparam int SAT_IIR1_OF  = 4;
  localparam int SAT_IIR1_UF  = 5;
  localparam int SAT_FRAC_OF  = 6;
  localparam int SAT_FRAC_UF  = 7;
  localparam int SAT_CIC_OF   = 8;
  localparam int SAT_CIC_UF   = 9;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/chain_fifo_mem.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one combinational read port.
// Contents are intentionally not reset; occupancy tracking in the parent decides what is valid.
module chain_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/chain_output_buffer.sv
// DFE output stage: FWFT FIFO, 1-cycle valid_in->m_valid; m_ready stalls reads, writes while full are dropped and counted.
// Define DFE_STATUS_STICKY_EN for sticky saturation status (cleared by status_clr); default is a 1-cycle registered copy.
module chain_output_buffer
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_WIDTH-1:0]    buf_in,
  input  logic [NUM_SAT_FLAGS-1:0] sat_flags_in,
  input  logic                     status_clr,
  input  logic                     m_ready,
  output logic                     m_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     drop_pulse,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [NUM_SAT_FLAGS-1:0] status
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [AW:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     drop_pulse_q, drop_pulse_d;
  logic [CNT_WIDTH-1:0]     drop_count_q, drop_count_d;
  logic [NUM_SAT_FLAGS-1:0] status_q, status_d;
  logic                     wr_en, rd_en, drop;

  // Flags depend on registered pointers only, so a same-cycle read never frees a slot for a write.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign m_valid = !empty;

  assign wr_en = valid_in && !full;
  assign drop  = valid_in && full;
  assign rd_en = m_valid && m_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_count_d = drop_count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_WIDTH'(1);
    drop_pulse_d = drop;
  end

`ifdef DFE_STATUS_STICKY_EN
  // A flag raised in the clear cycle must survive the clear.
  always_comb begin
    status_d = sat_flags_in | (status_clr ? '0 : status_q);
  end
`else
  logic status_clr_unused;
  assign status_clr_unused = status_clr;

  always_comb begin
    status_d = sat_flags_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
      status_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
      status_q     <= status_d;
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;
  assign status     = status_q;

  chain_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (buf_in),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (m_data)
  );

endmodule

// File: tb/tb_chain_output_buffer.sv
// Bench for chain_output_buffer: directed stimulus with a scoreboard queue checked by a separate output monitor.
module tb_chain_output_buffer;
  import dfe_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] buf_in = '0;
  logic [9:0]    sat_flags_in = '0;
  logic          status_clr = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [4:0]    level;
  logic          full, empty, drop_pulse;
  logic [CW-1:0] drop_count;
  logic [9:0]    status;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];
  int mlevel = 0;
  int mdrop  = 0;

  always #5 clk = ~clk;

  chain_output_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .buf_in(buf_in),
    .sat_flags_in(sat_flags_in), .status_clr(status_clr), .m_ready(m_ready),
    .m_valid(m_valid), .m_data(m_data), .level(level), .full(full), .empty(empty),
    .drop_pulse(drop_pulse), .drop_count(drop_count), .status(status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat must match the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
      else chk("sb_data", 32'(m_data), 32'(sb.pop_front()));
    end
  end

  // Drive one cycle of stimulus and advance the reference occupancy/drop model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    logic acc, rd;
    valid_in = v;
    buf_in   = d;
    m_ready  = r;
    acc = v && (mlevel < DEPTH);
    rd  = r && (mlevel > 0);
    if (acc) sb.push_back(d);
    if (v && !acc && mdrop < 255) mdrop++;
    mlevel = mlevel + int'(acc) - int'(rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    sample_t s0, s1, s2;
    s0 = 16'sh1234;
    s1 = 16'sh8000;
    s2 = 16'sh7FFF;

    #12;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_drop_pulse", 32'(drop_pulse), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    chk("rst_status", 32'(status), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three samples held back by the consumer, then drained in order.
    step(1'b1, s0, 1'b0);
    chk("t1_level1", 32'(level), 1);
    chk("t1_head", 32'(m_data), 32'h1234);
    chk("t1_m_valid", 32'(m_valid), 1);
    step(1'b1, s1, 1'b0);
    chk("t1_level2", 32'(level), 2);
    step(1'b1, s2, 1'b0);
    chk("t1_level3", 32'(level), 3);
    chk("t1_head_held", 32'(m_data), 32'h1234);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("t1_empty", 32'(empty), 1);
    chk("t1_level0", 32'(level), 0);

    // Fill, overflow by two, then a simultaneous read/write at full.
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    chk("t2_full", 32'(full), 1);
    chk("t2_level16", 32'(level), 16);
    step(1'b1, 16'hDEAD, 1'b0);
    chk("t2_drop_pulse1", 32'(drop_pulse), 1);
    step(1'b1, 16'hDEAE, 1'b0);
    chk("t2_drop_pulse2", 32'(drop_pulse), 1);
    chk("t2_drop_count", 32'(drop_count), 2);
    step(1'b1, 16'hBEEF, 1'b1);
    chk("t3_level15", 32'(level), 15);
    chk("t3_drop_count", 32'(drop_count), 3);
    chk("t3_full_clear", 32'(full), 0);
    step(1'b0, '0, 1'b1);
    chk("t3_drop_pulse_low", 32'(drop_pulse), 0);
    for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1);
    chk("t3_empty", 32'(empty), 1);

    // Steady streaming at level 5 across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h2000 + i), 1'b0);
    chk("t4_level5", 32'(level), 5);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 16'(16'h3000 + i), 1'b1);
      chk("t4_level_steady", 32'(level), 5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    chk("t4_empty", 32'(empty), 1);

    // Saturating drop counter.
    for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h4000 + i), 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 16'h5555, 1'b0);
    chk("t5_drop_sat", 32'(drop_count), 255);
    chk("t5_drop_model", 32'(drop_count), 32'(mdrop));

    // Asynchronous reset at level 7.
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1);
    m_ready = 1'b0;
    chk("t6_level7", 32'(level), 7);
    rst_n = 1'b0;
    #2;
    chk("t6_async_m_valid", 32'(m_valid), 0);
    chk("t6_async_level", 32'(level), 0);
    sb.delete();
    mlevel = 0;
    mdrop  = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_level0", 32'(level), 0);
    chk("t6_drop_count0", 32'(drop_count), 0);
    chk("t6_empty", 32'(empty), 1);
    step(1'b0, '0, 1'b0);

    // Saturation status aggregation.
    sat_flags_in = 10'h001;
    step(1'b0, '0, 1'b0);
    chk("t7_status_a", 32'(status), 32'h001);
    sat_flags_in = 10'h200;
    step(1'b0, '0, 1'b0);
`ifdef DFE_STATUS_STICKY_EN
    chk("t7_status_b", 32'(status), 32'h201);
`else
    chk("t7_status_b", 32'(status), 32'h200);
`endif
    sat_flags_in = 10'h000;
    step(1'b0, '0, 1'b0);
`ifdef DFE_STATUS_STICKY_EN
    chk("t7_status_hold", 32'(status), 32'h201);
`else
    chk("t7_status_hold", 32'(status), 32'h000);
`endif
    sat_flags_in = 10'h004;
    status_clr   = 1'b1;
    step(1'b0, '0, 1'b0);
    chk("t7_status_clr", 32'(status), 32'h004);
    sat_flags_in = 10'h000;
    status_clr   = 1'b0;
    step(1'b0, '0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
